// File: rtl/tx_line_packetizer_pkg.sv
// Shared constants and types for the per-channel line packetizer.
// Also imported by the receive-side collector so both agree on framing.
package tx_line_packetizer_pkg;

    localparam int WORDS_PER_LINE = 80;
    localparam int LINES          = 480;
    localparam int DW             = 12;
    localparam int AW             = 16;
    localparam int GAP_CYCLES     = 8;

    localparam int IDX_W  = $clog2(WORDS_PER_LINE);
    localparam int LINE_W = $clog2(LINES);
    localparam int GAP_W  = $clog2(GAP_CYCLES);

    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(WORDS_PER_LINE - 1);
    localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(LINES - 1);
    localparam logic [GAP_W-1:0]  LAST_GAP  = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        DATA,
        GAP
    } tx_state_e;

    // Frame-memory start address of a line.
    function automatic logic [AW-1:0] line_addr(input logic [LINE_W-1:0] line);
        line_addr = AW'(line) * AW'(WORDS_PER_LINE);
    endfunction

endpackage

// File: rtl/tx_line_buffer.sv
// Two-bank line buffer: simple dual-port RAM, one write port, one
// registered read port (1-cycle latency). Location = {bank, index}.
module tx_line_buffer
    import tx_line_packetizer_pkg::*;
(
    input  logic             clk,
    input  logic             we,
    input  logic             wbank,
    input  logic [IDX_W-1:0] widx,
    input  logic [DW-1:0]    wdata,
    input  logic             rbank,
    input  logic [IDX_W-1:0] ridx,
    output logic [DW-1:0]    rdata
);

    logic [DW-1:0] mem [2][WORDS_PER_LINE];
    logic [DW-1:0] rdata_q;
    logic [DW-1:0] rdata_d;

    always_comb begin
        rdata_d = mem[rbank][ridx];
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wbank][widx] <= wdata;
        end
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/tx_line_packetizer.sv
// Buffers one channel's pixel words a line at a time (ping-pong banks)
// and sends each line as {address header, WORDS_PER_LINE data words}.
module tx_line_packetizer
    import tx_line_packetizer_pkg::*;
(
    input  logic          Cclk,
    input  logic          rst,
    input  logic          FrameStart,
    input  logic          PixValid,
    input  logic [DW-1:0] PixData,
    input  logic          TxReady,
    output logic [AW-1:0] TxAdd,
    output logic          TxAddValid,
    output logic [DW-1:0] TxData,
    output logic          TxValid,
    output logic          LineDropped,
    output logic          Busy
);

    logic [IDX_W-1:0]            wcnt_q, wcnt_d;
    logic [LINE_W-1:0]           wline_q, wline_d;
    logic                        wbank_q, wbank_d;
    logic                        drop_q, drop_d;
    logic [1:0]                  full_q, full_d;
    logic [1:0][LINE_W-1:0]      sline_q, sline_d;
    logic                        line_dropped_q, line_dropped_d;

    tx_state_e                   state_q, state_d;
    logic                        rbank_q, rbank_d;
    logic [IDX_W-1:0]            rcnt_q, rcnt_d;
    logic [IDX_W-1:0]            ridx_q, ridx_d;
    logic [GAP_W-1:0]            gcnt_q, gcnt_d;
    logic [AW-1:0]               tx_add_q, tx_add_d;
    logic                        tx_add_valid_q, tx_add_valid_d;
    logic [DW-1:0]               tx_data_q, tx_data_d;
    logic                        tx_valid_q, tx_valid_d;

    logic [IDX_W-1:0]            eff_cnt;
    logic [LINE_W-1:0]           eff_line;
    logic                        eff_drop;
    logic                        drop_now;
    logic                        ram_we;
    logic [DW-1:0]               ram_rdata;
    logic [1:0]                  set_full;
    logic [1:0]                  clr_full;

    tx_line_buffer u_buf (
        .clk   (Cclk),
        .we    (ram_we),
        .wbank (wbank_q),
        .widx  (eff_cnt),
        .wdata (PixData),
        .rbank (rbank_q),
        .ridx  (ridx_d),
        .rdata (ram_rdata)
    );

    // Write side. FrameStart acts as if the counters were already zero,
    // so a coincident pixel becomes word 0 of line 0.
    always_comb begin
        wcnt_d         = wcnt_q;
        wline_d        = wline_q;
        wbank_d        = wbank_q;
        drop_d         = drop_q;
        sline_d        = sline_q;
        line_dropped_d = 1'b0;
        ram_we         = 1'b0;
        set_full       = 2'b00;
        eff_cnt        = FrameStart ? '0 : wcnt_q;
        eff_line       = FrameStart ? '0 : wline_q;
        eff_drop       = FrameStart ? 1'b0 : drop_q;
        // The drop decision is taken once, at the first word of a line.
        drop_now       = (eff_cnt == '0) ? full_q[wbank_q] : eff_drop;
        if (FrameStart) begin
            wcnt_d  = '0;
            wline_d = '0;
            drop_d  = 1'b0;
        end
        if (PixValid) begin
            ram_we = !drop_now;
            drop_d = drop_now;
            if (eff_cnt == LAST_IDX) begin
                wcnt_d  = '0;
                drop_d  = 1'b0;
                wline_d = (eff_line == LAST_LINE) ? '0 : eff_line + 1'b1;
                if (drop_now) begin
                    line_dropped_d = 1'b1;
                end else begin
                    set_full[wbank_q] = 1'b1;
                    sline_d[wbank_q]  = eff_line;
                    wbank_d           = !wbank_q;
                end
            end else begin
                wcnt_d = eff_cnt + 1'b1;
            end
        end
    end

    // Read side. ridx runs one word ahead of TxData so the registered
    // RAM output always holds the next word to send.
    always_comb begin
        state_d        = state_q;
        rbank_d        = rbank_q;
        rcnt_d         = rcnt_q;
        ridx_d         = ridx_q;
        gcnt_d         = gcnt_q;
        tx_add_d       = tx_add_q;
        tx_add_valid_d = tx_add_valid_q;
        tx_data_d      = tx_data_q;
        tx_valid_d     = tx_valid_q;
        clr_full       = 2'b00;
        unique case (state_q)
            IDLE: begin
                ridx_d = '0;
                if (full_q[rbank_q]) begin
                    tx_add_d       = line_addr(sline_q[rbank_q]);
                    tx_add_valid_d = 1'b1;
                    state_d        = HDR;
                end
            end
            HDR: begin
                if (TxReady) begin
                    tx_add_valid_d = 1'b0;
                    tx_data_d      = ram_rdata;
                    tx_valid_d     = 1'b1;
                    rcnt_d         = '0;
                    ridx_d         = IDX_W'(1);
                    state_d        = DATA;
                end
            end
            DATA: begin
                if (TxReady) begin
                    if (rcnt_q == LAST_IDX) begin
                        tx_valid_d        = 1'b0;
                        clr_full[rbank_q] = 1'b1;
                        rbank_d           = !rbank_q;
                        gcnt_d            = '0;
                        state_d           = GAP;
                    end else begin
                        tx_data_d = ram_rdata;
                        rcnt_d    = rcnt_q + 1'b1;
                        if (ridx_q != LAST_IDX) begin
                            ridx_d = ridx_q + 1'b1;
                        end
                    end
                end
            end
            GAP: begin
                if (gcnt_q == LAST_GAP) begin
                    state_d = IDLE;
                end else begin
                    gcnt_d = gcnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Clear wins if both ever hit the same bank.
    assign full_d = (full_q | set_full) & ~clr_full;

    always_ff @(posedge Cclk) begin
        if (rst) begin
            wcnt_q         <= '0;
            wline_q        <= '0;
            wbank_q        <= 1'b0;
            drop_q         <= 1'b0;
            full_q         <= 2'b00;
            sline_q        <= '0;
            line_dropped_q <= 1'b0;
            state_q        <= IDLE;
            rbank_q        <= 1'b0;
            rcnt_q         <= '0;
            ridx_q         <= '0;
            gcnt_q         <= '0;
            tx_add_q       <= '0;
            tx_add_valid_q <= 1'b0;
            tx_data_q      <= '0;
            tx_valid_q     <= 1'b0;
        end else begin
            wcnt_q         <= wcnt_d;
            wline_q        <= wline_d;
            wbank_q        <= wbank_d;
            drop_q         <= drop_d;
            full_q         <= full_d;
            sline_q        <= sline_d;
            line_dropped_q <= line_dropped_d;
            state_q        <= state_d;
            rbank_q        <= rbank_d;
            rcnt_q         <= rcnt_d;
            ridx_q         <= ridx_d;
            gcnt_q         <= gcnt_d;
            tx_add_q       <= tx_add_d;
            tx_add_valid_q <= tx_add_valid_d;
            tx_data_q      <= tx_data_d;
            tx_valid_q     <= tx_valid_d;
        end
    end

    assign TxAdd       = tx_add_q;
    assign TxAddValid  = tx_add_valid_q;
    assign TxData      = tx_data_q;
    assign TxValid     = tx_valid_q;
    assign LineDropped = line_dropped_q;
    assign Busy        = (state_q != IDLE);

endmodule

// File: tb/tb_tx_line_packetizer.sv
// Directed bench for tx_line_packetizer: feeds lines, logs accepted
// header/data words on the falling edge and compares to expectations.
module tb_tx_line_packetizer;

    localparam int WPL = 80;

    logic        Cclk = 1'b0;
    logic        rst = 1'b1;
    logic        FrameStart = 1'b0;
    logic        PixValid = 1'b0;
    logic [11:0] PixData = '0;
    logic        TxReady = 1'b0;
    logic [15:0] TxAdd;
    logic        TxAddValid;
    logic [11:0] TxData;
    logic        TxValid;
    logic        LineDropped;
    logic        Busy;

    tx_line_packetizer dut (
        .Cclk        (Cclk),
        .rst         (rst),
        .FrameStart  (FrameStart),
        .PixValid    (PixValid),
        .PixData     (PixData),
        .TxReady     (TxReady),
        .TxAdd       (TxAdd),
        .TxAddValid  (TxAddValid),
        .TxData      (TxData),
        .TxValid     (TxValid),
        .LineDropped (LineDropped),
        .Busy        (Busy)
    );

    always #5 Cclk = ~Cclk;

    int n_checks = 0;
    int n_pass = 0;
    int hdr_q[$];
    int hdr_t[$];
    int dat_q[$];
    int dat_t[$];
    int av_cycles = 0;
    int drops = 0;
    int stall_err = 0;
    int cyc = 0;
    bit rand_mode = 1'b0;
    bit fixed_ready = 1'b0;
    bit prev_stall = 1'b0;
    bit prev_rst = 1'b0;
    logic [11:0] prev_data = '0;

    always @(posedge Cclk) begin
        cyc++;
        #1;
        TxReady = rand_mode ? 1'($urandom_range(0, 1)) : fixed_ready;
    end

    always @(negedge Cclk) begin
        if (TxAddValid) av_cycles++;
        if (TxAddValid && TxReady) begin
            hdr_q.push_back(int'(TxAdd));
            hdr_t.push_back(cyc);
        end
        if (TxValid && TxReady) begin
            dat_q.push_back(int'(TxData));
            dat_t.push_back(cyc);
        end
        if (LineDropped) drops++;
        if (prev_stall && !prev_rst && (!TxValid || TxData != prev_data))
            stall_err++;
        prev_stall = TxValid && !TxReady;
        prev_data  = TxData;
        prev_rst   = rst;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge Cclk);
        #1;
    endtask

    task automatic feed_line(input int start, input bit fs_first);
        for (int i = 0; i < WPL; i++) begin
            FrameStart = fs_first && (i == 0);
            PixValid   = 1'b1;
            PixData    = 12'(start + i);
            tick();
        end
        FrameStart = 1'b0;
        PixValid   = 1'b0;
    endtask

    task automatic frame_start();
        FrameStart = 1'b1;
        tick();
        FrameStart = 1'b0;
    endtask

    task automatic clear_logs();
        hdr_q.delete();
        hdr_t.delete();
        dat_q.delete();
        dat_t.delete();
        av_cycles = 0;
        drops     = 0;
        stall_err = 0;
    endtask

    task automatic wait_done(input string tag, input int nh, input int nd);
        int c;
        bit ok;
        c  = 0;
        ok = 1'b0;
        while (c < 3000 && !ok) begin
            ok = hdr_q.size() >= nh && dat_q.size() >= nd && !Busy;
            if (!ok) begin
                tick();
                c++;
            end
        end
        check(tag, int'(ok), 1);
    endtask

    task automatic check_pkt(input string tag, input int p,
                             input int addr, input int start);
        int idx;
        check({tag, "_hdr"}, (p < hdr_q.size()) ? hdr_q[p] : -1, addr);
        for (int i = 0; i < WPL; i++) begin
            idx = p * WPL + i;
            check($sformatf("%s_d%0d", tag, i),
                  (idx < dat_q.size()) ? dat_q[idx] : -1,
                  (start + i) & 'hFFF);
        end
    endtask

    initial begin
        int mg;
        int n_d;
        int n_h;
        int c;

        // Reset state
        repeat (3) tick();
        rst = 1'b0;
        @(negedge Cclk);
        check("rst_txadd", int'(TxAdd), 0);
        check("rst_addvalid", int'(TxAddValid), 0);
        check("rst_txdata", int'(TxData), 0);
        check("rst_txvalid", int'(TxValid), 0);
        check("rst_dropped", int'(LineDropped), 0);
        check("rst_busy", int'(Busy), 0);

        // 1: two lines, link always ready
        fixed_ready = 1'b1;
        tick();
        clear_logs();
        frame_start();
        feed_line('h000, 1'b0);
        feed_line('h050, 1'b0);
        wait_done("t1_wait", 2, 2 * WPL);
        check_pkt("t1p0", 0, 'h0000, 'h000);
        check_pkt("t1p1", 1, 'h0050, 'h050);
        check("t1_hdr_cycles", av_cycles, 2);
        check("t1_burst", (dat_t.size() >= WPL) ? dat_t[WPL-1] - dat_t[0] : -1,
              WPL - 1);
        check("t1_count", dat_q.size(), 2 * WPL);

        // 2: same traffic, random backpressure
        clear_logs();
        rand_mode = 1'b1;
        frame_start();
        feed_line('h000, 1'b0);
        feed_line('h050, 1'b0);
        wait_done("t2_wait", 2, 2 * WPL);
        rand_mode = 1'b0;
        tick();
        check_pkt("t2p0", 0, 'h0000, 'h000);
        check_pkt("t2p1", 1, 'h0050, 'h050);
        check("t2_hdrs", hdr_q.size(), 2);
        check("t2_count", dat_q.size(), 2 * WPL);
        check("t2_stall", stall_err, 0);
        check("t2_drops", drops, 0);

        // 3: link blocked, third line must drop
        fixed_ready = 1'b0;
        tick();
        clear_logs();
        frame_start();
        feed_line('h100, 1'b0);
        feed_line('h200, 1'b0);
        tick();
        check("t3_nodrop", drops, 0);
        feed_line('h300, 1'b0);
        tick();
        tick();
        check("t3_drop", drops, 1);
        check("t3_held", hdr_q.size(), 0);
        fixed_ready = 1'b1;
        wait_done("t3_wait", 2, 2 * WPL);
        check_pkt("t3p0", 0, 'h0000, 'h100);
        check_pkt("t3p1", 1, 'h0050, 'h200);
        check("t3_hdrs", hdr_q.size(), 2);
        check("t3_count", dat_q.size(), 2 * WPL);
        feed_line('h400, 1'b0);
        wait_done("t3_wait4", 3, 3 * WPL);
        check_pkt("t3p2", 2, 'h00F0, 'h400);
        check("t3_drops_end", drops, 1);

        // 4: partial line discarded by FrameStart (coincident with word 0)
        clear_logs();
        frame_start();
        for (int i = 0; i < 30; i++) begin
            PixValid = 1'b1;
            PixData  = 12'('h500 + i);
            tick();
        end
        PixValid = 1'b0;
        feed_line('h600, 1'b1);
        wait_done("t4_wait", 1, WPL);
        repeat (30) tick();
        check("t4_hdrs", hdr_q.size(), 1);
        check("t4_count", dat_q.size(), WPL);
        check_pkt("t4p0", 0, 'h0000, 'h600);

        // 5: line number wrap over a full frame plus one
        clear_logs();
        frame_start();
        for (int l = 0; l < 481; l++) begin
            feed_line(l, 1'b0);
            repeat (12) tick();
        end
        wait_done("t5_wait", 481, 481 * WPL);
        check("t5_hdrs", hdr_q.size(), 481);
        check("t5_drops", drops, 0);
        check("t5_h1", (hdr_q.size() > 1) ? hdr_q[1] : -1, 'h0050);
        check_pkt("t5p479", 479, 'h95B0, 479);
        check_pkt("t5p480", 480, 'h0000, 480);
        mg = 1000000;
        for (int p = 1; p < hdr_t.size(); p++)
            if (hdr_t[p] - hdr_t[p-1] < mg) mg = hdr_t[p] - hdr_t[p-1];
        check("t5_gap_ok", int'(mg >= 8), 1);

        // 6: reset in the middle of a packet
        clear_logs();
        frame_start();
        feed_line('h700, 1'b0);
        c = 0;
        while (c < 500 && dat_q.size() < 40) begin
            @(negedge Cclk);
            c++;
        end
        check("t6_reach40", int'(dat_q.size() >= 40), 1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge Cclk);
        check("t6_txadd", int'(TxAdd), 0);
        check("t6_addvalid", int'(TxAddValid), 0);
        check("t6_txdata", int'(TxData), 0);
        check("t6_txvalid", int'(TxValid), 0);
        check("t6_dropped", int'(LineDropped), 0);
        check("t6_busy", int'(Busy), 0);
        n_d = dat_q.size();
        n_h = hdr_q.size();
        repeat (200) tick();
        check("t6_quiet_d", dat_q.size(), n_d);
        check("t6_quiet_h", hdr_q.size(), n_h);
        clear_logs();
        feed_line('h800, 1'b0);
        wait_done("t6_wait", 1, WPL);
        check_pkt("t6p0", 0, 'h0000, 'h800);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
